serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial N-bit subtractor built around a single registered full-subtractor cell, consuming one operand bit pair per clock, LSB first. It is the inverse companion of the tutorial full-adder cell (sum/carry becomes difference/borrow). It latches two parallel operands on a start handshake, iterates WIDTH cycles, and presents a held parallel result with a one-cycle done strobe. It is intended as the sequential example circuit alongside the combinational adder pages, driven by switches and observed on LEDs.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request strobe; sampled on a rising edge only while busy=0.
- a  in  WIDTH  minuend; sampled with an accepted start.
- b  in  WIDTH  subtrahend; sampled with an accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle strobe when the result is valid.
- diff  out  WIDTH  a − b mod 2^WIDTH; held until the next accepted start.
- borrow_out  out  1  final borrow, 1 exactly when a < b (unsigned); held with diff.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on start.
  - SHIFT stays in SHIFT while bit counter < WIDTH−1.
  - SHIFT → DONE after bit WIDTH−1.
  - DONE → SHIFT if start, else DONE → IDLE.
- Accept:
  - start is accepted when state is IDLE or DONE.
  - On accept: a and b are loaded into shift registers, borrow register is cleared to 0, bit counter is cleared to 0, and diff/borrow_out are cleared to 0.
- SHIFT, each cycle:
  - d = a0 ^ b0 ^ bin.
  - bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - d is shifted into the MSB of the diff register (right shift); operand registers shift right.
  - The borrow register takes bout; the counter increments.
- After WIDTH cycles, diff holds the full result LSB-aligned. On the SHIFT→DONE transition, borrow_out ← final borrow.
- start during SHIFT is ignored; a and b changes during SHIFT have no effect.
- Counter width is $clog2(WIDTH). No wrap occurs because the counter is cleared on each accept.
- Reset (rst_n=0 at an edge), from any state including mid-SHIFT:
  - state → IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - counter, operand and borrow registers all cleared.
  - An in-flight operation is discarded with no done.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0.
- All outputs are registered; no combinational path from any input to any output.
- start accepted at edge k:
  - busy=1 for cycles k+1 through k+WIDTH.
  - done=1 for exactly the one cycle after edge k+WIDTH.
  - diff and borrow_out are valid from that same edge.
  - Start-to-done latency is WIDTH cycles; throughput is one operation per WIDTH+1 cycles back-to-back.
- Back-to-back: a start during the DONE cycle is accepted. That edge clears diff and borrow_out and raises busy, so the result is visible for only the done cycle. Consumers must capture it on done.
- start and rst_n=0 at the same edge: reset wins.
- busy and done are never high in the same cycle.

## Structure
- Package serial_subtractor_pkg:
  - state enum {IDLE, SHIFT, DONE}, 2-bit encoding.
  - function for counter width.
- Sub-module full_subtractor: combinational one-bit cell (a, b, bin → d, bout), instantiated once. This mirrors the existing full-adder cell, so it stays reusable on the tutorial pages.
- Top module holds the FSM, counter, operand/result shift registers and borrow flop.

## Test plan
- WIDTH=8, reset, then a=5, b=3, start at edge 0 → busy high for cycles 1–8; done at cycle 9 with diff=0x02, borrow_out=0.
- a=3, b=5 → diff=0xFE, borrow_out=1; a=0x00, b=0xFF → diff=0x01, borrow_out=1; a=b=0xA5 → diff=0x00, borrow_out=0.
- Start at edge 0 with 5−3, then at edge 3 pulse start with a=9, b=1 → pulse ignored; done at cycle 9 with diff=0x02.
- rst_n low at edge 4 mid-SHIFT → next cycle busy=0, diff=0; no done within the following 12 cycles without a start.
- Start in the DONE cycle with a=0x80, b=0x01 → busy rises the next cycle; done 8 cycles later with diff=0x7F, borrow_out=0.
- Random 1000 operand pairs at WIDTH=8 and WIDTH=2 → diff and borrow_out match a reference model; done is always exactly WIDTH cycles after the accepted start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Imported by the top-level serial_subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow.
// Companion to the tutorial full-adder cell.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: latches a and b on start, processes one bit
// per clock LSB first, then presents diff/borrow_out with a one-cycle done strobe.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             busy_q;
    logic             done_q;
    logic             borrow_out_q;
    logic             d_s;
    logic             bout_s;

    full_subtractor u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (bin_q),
        .d_o    (d_s),
        .bout_o (bout_s)
    );

    // Control FSM, operand/result shift registers, borrow flop and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            bin_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= SHIFT;
                        a_q          <= a;
                        b_q          <= b;
                        diff_q       <= '0;
                        cnt_q        <= '0;
                        bin_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        borrow_out_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_q    <= {1'b0, a_q[WIDTH-1:1]};
                    b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    diff_q <= {d_s, diff_q[WIDTH-1:1]};
                    bin_q  <= bout_s;
                    if (cnt_q == LAST) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        borrow_out_q <= bout_s;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    a_q          <= '0;
                    b_q          <= '0;
                    diff_q       <= '0;
                    cnt_q        <= '0;
                    bin_q        <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    borrow_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
